// File: rtl/line_buffer_ctrl_if.sv
// Bus between line_buffer_ctrl (slave) and its field sink / frame source (master).
// LBC_ERR_CNT_EN adds the err_cnt status output.
interface line_buffer_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       wr_req0;
    logic       wr_req1;
    logic       rd_req0;
    logic       rd_req1;
    logic       full0;
    logic       full1;
    logic       empty_enable0;
    logic       empty_enable1;
    logic       ready_to_continue;
    logic       aver_sent;
    logic       frame_done;
    logic [1:0] bank0_state;
    logic [1:0] bank1_state;
`ifdef LBC_ERR_CNT_EN
    logic [7:0] err_cnt;

    modport master (
        output in_valid, rd_req0, rd_req1, aver_sent,
        input  in_ready, wr_req0, wr_req1, full0, full1, empty_enable0, empty_enable1,
               ready_to_continue, frame_done, bank0_state, bank1_state, err_cnt
    );
    modport slave (
        input  in_valid, rd_req0, rd_req1, aver_sent,
        output in_ready, wr_req0, wr_req1, full0, full1, empty_enable0, empty_enable1,
               ready_to_continue, frame_done, bank0_state, bank1_state, err_cnt
    );
`else
    modport master (
        output in_valid, rd_req0, rd_req1, aver_sent,
        input  in_ready, wr_req0, wr_req1, full0, full1, empty_enable0, empty_enable1,
               ready_to_continue, frame_done, bank0_state, bank1_state
    );
    modport slave (
        input  in_valid, rd_req0, rd_req1, aver_sent,
        output in_ready, wr_req0, wr_req1, full0, full1, empty_enable0, empty_enable1,
               ready_to_continue, frame_done, bank0_state, bank1_state
    );
`endif
endinterface

// File: rtl/line_buffer_ctrl.sv
// Ping-pong scheduler for two single-line buffers between field sink and frame source.
// Define LBC_ERR_CNT_EN to add a saturating protocol-error counter (err_cnt).
module line_buffer_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int WIDTH       = 640,
    parameter int HALF_HEIGHT = 240
) (
    input logic          clock,
    input logic          reset,
    line_buffer_ctrl_if.slave bus
);
    localparam int WC_W = $clog2(WIDTH + 1);
    localparam int LC_W = $clog2(HALF_HEIGHT + 1);
    localparam logic [WC_W-1:0] PIX_LAST = WC_W'(WIDTH - 1);
    localparam logic [LC_W-1:0] LINE_MAX = LC_W'(HALF_HEIGHT);

    // DATA_WIDTH is carried only so the parameter set matches the pixel buffers.
    if (DATA_WIDTH < 1) begin : g_bad_data_width
    end

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FILLING  = 2'd1,
        ST_FULL     = 2'd2,
        ST_DRAINING = 2'd3
    } bank_state_e;

    bank_state_e     state_q [2];
    bank_state_e     state_d [2];
    logic [WC_W-1:0] rd_cnt_q [2];
    logic [WC_W-1:0] rd_cnt_d [2];
    logic [WC_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [LC_W-1:0] line_cnt_q, line_cnt_d;
    logic            wr_sel_q, wr_sel_d;
    logic            ec_sel_q, ec_sel_d;
    logic            ack_pend_q, ack_pend_d;
    logic            rtc_q, rtc_d;
    logic [1:0]      full_q;
    logic [1:0]      has_line;
    logic [1:0]      rd_req;
    logic            in_ready, xfer, frame_done, ec_toggle;

    // Handshake: a pixel moves when in_valid & in_ready in the same cycle; in_valid
    // may be held without a transfer, and wr_reqN mirrors the transfer combinationally.
    assign rd_req = {bus.rd_req1, bus.rd_req0};

    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        line_cnt_d = line_cnt_q;
        wr_sel_d   = wr_sel_q;
        ec_sel_d   = ec_sel_q;
        ack_pend_d = ack_pend_q;
        ec_toggle  = 1'b0;
        has_line   = 2'b00;

        in_ready   = ((state_q[wr_sel_q] == ST_EMPTY) || (state_q[wr_sel_q] == ST_FILLING)) &&
                     (line_cnt_q < LINE_MAX);
        xfer       = bus.in_valid & in_ready;
        frame_done = (line_cnt_q == LINE_MAX) && (state_q[0] == ST_EMPTY) &&
                     (state_q[1] == ST_EMPTY);

        for (int n = 0; n < 2; n++) begin
            has_line[n] = (state_q[n] == ST_FULL) || (state_q[n] == ST_DRAINING);
            if (rd_req[n] && has_line[n]) begin
                if (rd_cnt_q[n] == PIX_LAST) begin
                    rd_cnt_d[n] = '0;
                    if (ec_sel_q == 1'(n)) begin
                        state_d[n] = ST_EMPTY;
                        ec_toggle  = 1'b1;
                    end else begin
                        state_d[n] = ST_FULL;  // not the consumed bank: rewind for re-read
                    end
                end else begin
                    rd_cnt_d[n] = rd_cnt_q[n] + 1'b1;
                    state_d[n]  = ST_DRAINING;
                end
            end
        end

        if (xfer) begin
            if (wr_cnt_q == PIX_LAST) begin
                state_d[wr_sel_q] = ST_FULL;
                wr_cnt_d          = '0;
                wr_sel_d          = ~wr_sel_q;
                line_cnt_d        = line_cnt_q + 1'b1;
            end else begin
                state_d[wr_sel_q] = ST_FILLING;
                wr_cnt_d          = wr_cnt_q + 1'b1;
            end
        end

        if (ec_toggle) begin
            ec_sel_d   = ~ec_sel_q;
            ack_pend_d = 1'b0;
        end else if (bus.aver_sent && rtc_q) begin
            ack_pend_d = 1'b1;
        end

        if (frame_done) begin
            line_cnt_d = '0;
            wr_sel_d   = 1'b0;
            ec_sel_d   = 1'b0;
            ack_pend_d = 1'b0;
        end

        rtc_d = (~ack_pend_d && (state_d[~ec_sel_d] == ST_FULL)) || (line_cnt_d == LINE_MAX);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q[0]  <= ST_EMPTY;
            state_q[1]  <= ST_EMPTY;
            rd_cnt_q[0] <= '0;
            rd_cnt_q[1] <= '0;
            wr_cnt_q    <= '0;
            line_cnt_q  <= '0;
            wr_sel_q    <= 1'b0;
            ec_sel_q    <= 1'b0;
            ack_pend_q  <= 1'b0;
            rtc_q       <= 1'b0;
            full_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            line_cnt_q  <= line_cnt_d;
            wr_sel_q    <= wr_sel_d;
            ec_sel_q    <= ec_sel_d;
            ack_pend_q  <= ack_pend_d;
            rtc_q       <= rtc_d;
            full_q      <= has_line;
        end
    end

`ifdef LBC_ERR_CNT_EN
    logic       err_evt;
    logic [7:0] err_cnt_q;

    assign err_evt = (bus.in_valid & ~in_ready) | (rd_req[0] & ~has_line[0]) |
                     (rd_req[1] & ~has_line[1]) | (bus.aver_sent & ~rtc_q);

    always_ff @(posedge clock) begin
        if (!reset) begin
            err_cnt_q <= 8'd0;
        end else if (err_evt && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`endif

    assign bus.in_ready          = in_ready;
    assign bus.wr_req0           = xfer & ~wr_sel_q;
    assign bus.wr_req1           = xfer & wr_sel_q;
    assign bus.full0             = full_q[0];
    assign bus.full1             = full_q[1];
    assign bus.empty_enable0     = ~ec_sel_q;
    assign bus.empty_enable1     = ec_sel_q;
    assign bus.ready_to_continue = rtc_q;
    assign bus.frame_done        = frame_done;
    assign bus.bank0_state       = state_q[0];
    assign bus.bank1_state       = state_q[1];
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl with WIDTH=8, HALF_HEIGHT=4; directed vectors, corner
// sequences and random traffic against a pixel-occupancy model.
module tb_line_buffer_ctrl;
    localparam int W  = 8;
    localparam int HH = 4;

    logic clock;
    logic reset;
    line_buffer_ctrl_if bus ();

    line_buffer_ctrl #(.DATA_WIDTH(8), .WIDTH(W), .HALF_HEIGHT(HH)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pixels held per bank, reads done on a complete line, who is written / consumed.
    int pix [2];
    int rd  [2];
    int wsel, ec, lines, ack, rtc_m, err_m;
    int fm  [2];
    bit model_live = 1'b0;

    typedef struct packed {
        logic iv, r0, r1, av;
        logic e_rdy, e_w0, e_w1, e_f0, e_f1, e_rtc;
    } vec_t;
    vec_t vecs [11];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_n(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_state(input int n);
        if (pix[n] == 0) return 0;
        if (pix[n] < W)  return 1;
        if (rd[n] == 0)  return 2;
        return 3;
    endfunction

    task automatic model_reset();
        pix[0] = 0; pix[1] = 0; rd[0] = 0; rd[1] = 0; fm[0] = 0; fm[1] = 0;
        wsel = 0; ec = 0; lines = 0; ack = 0; rtc_m = 0; err_m = 0;
    endtask

    task automatic model_check();
        bit rdy, fd;
        rdy = (pix[wsel] < W) && (lines < HH);
        fd  = (lines == HH) && (pix[0] == 0) && (pix[1] == 0);
        check("in_ready", bus.in_ready, rdy);
        check("wr_req0", bus.wr_req0, bus.in_valid && rdy && (wsel == 0));
        check("wr_req1", bus.wr_req1, bus.in_valid && rdy && (wsel == 1));
        check("full0", bus.full0, fm[0] != 0);
        check("full1", bus.full1, fm[1] != 0);
        check("empty_enable0", bus.empty_enable0, ec == 0);
        check("empty_enable1", bus.empty_enable1, ec == 1);
        check("ready_to_continue", bus.ready_to_continue, rtc_m != 0);
        check("frame_done", bus.frame_done, fd);
        check_n("bank0_state", int'(bus.bank0_state), exp_state(0));
        check_n("bank1_state", int'(bus.bank1_state), exp_state(1));
`ifdef LBC_ERR_CNT_EN
        check_n("err_cnt", int'(bus.err_cnt), err_m);
`endif
    endtask

    task automatic model_update(input logic rst_n, input logic iv, input logic r0,
                                input logic r1, input logic av);
        bit rdy, fd, tog;
        int ecold;
        logic r [2];
        if (!rst_n) begin
            model_reset();
            model_live = 1'b1;
            return;
        end
        rdy = (pix[wsel] < W) && (lines < HH);
        fd  = (lines == HH) && (pix[0] == 0) && (pix[1] == 0);
        if (((iv && !rdy) || (r0 && pix[0] != W) || (r1 && pix[1] != W) ||
             (av && rtc_m == 0)) && err_m < 255)
            err_m++;
        fm[0] = (pix[0] == W); fm[1] = (pix[1] == W);
        r[0] = r0; r[1] = r1;
        ecold = ec;
        tog = 1'b0;
        for (int n = 0; n < 2; n++) begin
            if (r[n] && pix[n] == W) begin
                rd[n]++;
                if (rd[n] == W) begin
                    rd[n] = 0;
                    if (ecold == n) begin
                        pix[n] = 0;
                        tog = 1'b1;
                    end
                end
            end
        end
        if (tog) ec = 1 - ec;
        if (iv && rdy) begin
            pix[wsel]++;
            if (pix[wsel] == W) begin
                wsel = 1 - wsel;
                lines++;
            end
        end
        if (tog) ack = 0;
        else if (av && rtc_m != 0) ack = 1;
        if (fd) begin
            lines = 0; wsel = 0; ec = 0; ack = 0;
        end
        rtc_m = ((ack == 0 && pix[1-ec] == W && rd[1-ec] == 0) || lines == HH) ? 1 : 0;
    endtask

    // Drive one cycle's inputs after the falling edge, then compare before the next rise.
    task automatic step(input logic rst_n, input logic iv, input logic r0,
                        input logic r1, input logic av);
        @(negedge clock);
        reset         = rst_n;
        bus.in_valid  = iv;
        bus.rd_req0   = r0;
        bus.rd_req1   = r1;
        bus.aver_sent = av;
        #1;
        if (model_live) model_check();
        model_update(rst_n, iv, r0, r1, av);
    endtask

    initial begin
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.rd_req0 = 1'b0; bus.rd_req1 = 1'b0; bus.aver_sent = 1'b0;
        model_reset();

        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_empty_enable0", bus.empty_enable0, 1'b1);
        check("rst_empty_enable1", bus.empty_enable1, 1'b0);
        check("rst_full0", bus.full0, 1'b0);
        check("rst_rtc", bus.ready_to_continue, 1'b0);
        check("rst_frame_done", bus.frame_done, 1'b0);

        // Reset in the middle of a line must discard the partial fill.
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst_full0", bus.full0, 1'b0);
        check("midrst_full1", bus.full1, 1'b0);
        check("midrst_in_ready", bus.in_ready, 1'b1);
        check("midrst_empty_enable0", bus.empty_enable0, 1'b1);
        check_n("midrst_bank0_state", int'(bus.bank0_state), 0);

        // First line into bank 0: full0 rises two cycles after the last transfer.
        for (int i = 0; i < 8; i++) vecs[i] = 10'b1000_110000;
        vecs[8]  = 10'b0000_100000;
        vecs[9]  = 10'b0000_100100;
        vecs[10] = 10'b1000_101100;
        for (int i = 0; i < 11; i++) begin
            step(1'b1, vecs[i].iv, vecs[i].r0, vecs[i].r1, vecs[i].av);
            check($sformatf("vec%0d_in_ready", i), bus.in_ready, vecs[i].e_rdy);
            check($sformatf("vec%0d_wr_req0", i), bus.wr_req0, vecs[i].e_w0);
            check($sformatf("vec%0d_wr_req1", i), bus.wr_req1, vecs[i].e_w1);
            check($sformatf("vec%0d_full0", i), bus.full0, vecs[i].e_f0);
            check($sformatf("vec%0d_full1", i), bus.full1, vecs[i].e_f1);
            check($sformatf("vec%0d_rtc", i), bus.ready_to_continue, vecs[i].e_rtc);
        end

        // Complete bank 1, then hold in_valid against backpressure.
        repeat (7) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            check("blocked_in_ready", bus.in_ready, 1'b0);
            check("blocked_wr_req0", bus.wr_req0, 1'b0);
            check("blocked_wr_req1", bus.wr_req1, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("both_full_rtc", bus.ready_to_continue, 1'b1);
`ifdef LBC_ERR_CNT_EN
        check_n("blocked_err_cnt", int'(bus.err_cnt), 5);
`endif

        // Acknowledge drops ready_to_continue on the next cycle.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ack_rtc_low", bus.ready_to_continue, 1'b0);

        // Both banks read together: bank 0 consumed, bank 1 rewound.
        repeat (8) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("drain_full0", bus.full0, 1'b0);
        check("drain_full1", bus.full1, 1'b1);
        check("drain_empty_enable1", bus.empty_enable1, 1'b1);
        check("drain_in_ready", bus.in_ready, 1'b1);
        check("drain_rtc", bus.ready_to_continue, 1'b0);
        check_n("drain_bank1_state", int'(bus.bank1_state), 2);

        // Refill bank 0: the line behind bank 1 is ready again.
        repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("refill_rtc", bus.ready_to_continue, 1'b1);

        // Finish the field: consume bank 1, write the last line, drain both.
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("last_line_in_ready", bus.in_ready, 1'b0);
        check("last_line_rtc", bus.ready_to_continue, 1'b1);
        repeat (8) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("frame_done_pulse", bus.frame_done, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("frame_done_drop", bus.frame_done, 1'b0);
        check("new_field_in_ready", bus.in_ready, 1'b1);
        check("new_field_wr_req0", bus.wr_req0, 1'b1);

        // Random traffic against the model.
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 999) != 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
Ping-pong scheduler for the two single-line buffers (bank 0 / bank 1) that sit between the field sink and the frame source of the deinterlacer.
- Steers incoming field pixels into the free bank and applies backpressure to the sink.
- Publishes per-bank full status and selects which bank is consumed on read (empty_enable).
- Handles the ready_to_continue / aver_sent handshake with the source.
- Counts field lines and flags end of frame.

Parameters:
DATA_WIDTH, 8, pixel width (carried for consistency; no datapath inside this block)
WIDTH, 640, pixels per line
HALF_HEIGHT, 240, lines per field

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset (sampled on posedge clock; 0 = reset)
in_valid  in  1  sink has a field pixel this cycle
in_ready  out  1  controller accepts pixel (transfer = in_valid & in_ready)
wr_req0  out  1  write strobe, bank 0
wr_req1  out  1  write strobe, bank 1
rd_req0  in  1  source read strobe, bank 0
rd_req1  in  1  source read strobe, bank 1
full0  out  1  bank 0 holds a complete line
full1  out  1  bank 1 holds a complete line
empty_enable0  out  1  reads of bank 0 consume the line
empty_enable1  out  1  reads of bank 1 consume the line
ready_to_continue  out  1  next line available to source
aver_sent  in  1  one-cycle ack from source
frame_done  out  1  one-cycle pulse, field fully written and drained

Behaviour:
- Reset (reset==0 at a posedge; dominates all other inputs):
  - Both banks EMPTY, wr_sel=0, ec_sel=0 (bank to empty next), line_cnt=0, ack_pend=0.
  - All outputs 0 except in_ready=1 and empty_enable0=1.
- Per-bank FSM, states EMPTY, FILLING, FULL, DRAINING:
  - EMPTY -> FILLING on the first transfer while wr_sel selects the bank.
  - FILLING -> FULL when the wr_cnt==WIDTH-1 transfer completes. wr_cnt resets to 0, wr_sel toggles, line_cnt increments.
  - FULL -> DRAINING on the first rd_reqN.
  - DRAINING counts rd_reqN pulses in rd_cntN. At the WIDTH-th read:
    - empty_enableN==1: go EMPTY, toggle ec_sel.
    - else: go FULL (line rewound for re-read), rd_cntN=0.
- fullN = (state==FULL or DRAINING). Registered; updates the cycle after the state change.
- empty_enableN = (ec_sel==N). Exactly one of the two is high at all times.
- wr_reqN = in_valid & in_ready & (wr_sel==N). Combinational, same cycle as the transfer.
- in_ready = selected bank in EMPTY or FILLING, and line_cnt < HALF_HEIGHT. Combinational.
- Simultaneous events:
  - Read while the other bank fills: independent.
  - rd_reqN while bank N is EMPTY/FILLING: ignored and counted as a protocol error (see optional feature).
- Source handshake:
  - ready_to_continue is registered. It is 1 when ack_pend==0 and the bank with ec_sel^1 is FULL (next line ready behind the one being consumed), or when line_cnt==HALF_HEIGHT (no more lines coming).
  - aver_sent=1 sets ack_pend and drops ready_to_continue next cycle.
  - ack_pend clears when ec_sel toggles.
  - aver_sent while ready_to_continue==0: ignored.
- Frame end:
  - frame_done pulses one cycle when line_cnt==HALF_HEIGHT and both banks are EMPTY.
  - Same cycle: line_cnt=0, wr_sel=0, ec_sel=0, in_ready re-opens next cycle.
- Counters are sized ceil(log2(WIDTH+1)) / ceil(log2(HALF_HEIGHT+1)) and never wrap past their limit.

Optional Feature:
LBC_ERR_CNT_EN
- Defined:
  - Adds output err_cnt[7:0], saturating at 255, cleared by reset.
  - Increments once per cycle with any of:
    - in_valid & ~in_ready (dropped pixel);
    - rd_reqN on a bank not FULL/DRAINING;
    - aver_sent while ready_to_continue==0.
- Undefined: port and logic absent; those events are silently ignored.

Test Plan:
- Reset held low 3 cycles mid-fill (bank0 wr_cnt=100) -> next cycle: full0=full1=0, in_ready=1, empty_enable0=1, wr_cnt=0.
- WIDTH=8: 8 transfers -> wr_req0 on cycles 0-7; full0=1 on cycle 9; wr_sel=1; next transfer gives wr_req1.
- Both banks FULL, ec_sel=0, 8 rd_req0 + 8 rd_req1 -> bank0 EMPTY, full0=0; bank1 FULL; empty_enable1=1; in_ready=1.
- Both banks full -> in_ready=0, in_valid held 5 cycles -> no wr_req. With LBC_ERR_CNT_EN: err_cnt=5.
- ready_to_continue=1, aver_sent pulse -> ready_to_continue=0 next cycle; re-asserts only after ec_sel toggles and the other bank is FULL.
- HALF_HEIGHT=4, WIDTH=8: 32 pixels in, all lines drained with empty_enable -> frame_done one-cycle pulse; line_cnt=0; first pixel of next field goes to bank 0.
